// File: rtl/wb_bus_decoder_pkg.sv
// Shared Wishbone bus configuration used by the decoder and the core bus modules.
package wb_bus_decoder_pkg;

    localparam int WB_DATA_W   = 16;
    localparam int WB_ADDR_W   = 24;
    localparam int WB_SEL_BITS = 2;

    // Four slave regions, chosen by the two most significant address bits.
    localparam int NUM_SLAVES  = 4;
    localparam int SLAVE_IDX_W = 2;

    typedef logic [SLAVE_IDX_W-1:0] slave_idx_t;

    // Region index of a bus address (address bits [23:22]).
    function automatic slave_idx_t region_of(input logic [WB_ADDR_W-1:0] adr);
        return adr[WB_ADDR_W-1 -: SLAVE_IDX_W];
    endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Cycle watchdog: counts enabled cycles and flags when the last allowed cycle is reached.
module wb_timeout_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // TIMEOUT is limited to 2..255 so the final count fits in 8 bits.
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] count;

    // Count waiting cycles; clear wins over enable so a fresh cycle always starts at zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/wb_bus_decoder.sv
// Single-master Wishbone classic decoder fanning one master out to four slave regions,
// terminating cycles to disabled regions and hung slaves with an error.
module wb_bus_decoder
    import wb_bus_decoder_pkg::*;
#(
    parameter logic [3:0] SLAVE_EN = 4'b1111,
    parameter int         TIMEOUT  = 64
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          m_cyc,
    input  logic                          m_stb,
    input  logic                          m_we,
    input  logic [WB_ADDR_W-1:0]          m_adr,
    input  logic [WB_DATA_W-1:0]          m_dat_i,
    input  logic [WB_SEL_BITS-1:0]        m_sel,
    output logic [WB_DATA_W-1:0]          m_dat_o,
    output logic                          m_ack,
    output logic                          m_err,
    output logic                          m_rty,
    output logic [NUM_SLAVES-1:0]         s_cyc,
    output logic [NUM_SLAVES-1:0]         s_stb,
    output logic                          s_we,
    output logic [WB_ADDR_W-1:0]          s_adr,
    output logic [WB_DATA_W-1:0]          s_dat_o,
    output logic [WB_SEL_BITS-1:0]        s_sel,
    input  logic [NUM_SLAVES*WB_DATA_W-1:0] s_dat_i,
    input  logic [NUM_SLAVES-1:0]         s_ack,
    input  logic [NUM_SLAVES-1:0]         s_err,
    input  logic [NUM_SLAVES-1:0]         s_rty
);

    // Cycle tracking states; ERR is the one-cycle error termination.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ERR    = 2'd2
    } state_t;

    state_t     state;
    state_t     next_state;
    slave_idx_t sel_q;
    slave_idx_t req_idx;
    logic       accept;
    logic       tmo_clear;
    logic       tmo_en;
    logic       tmo_expired;

    assign req_idx = region_of(m_adr);
    assign accept  = m_cyc & m_stb & SLAVE_EN[req_idx];

    // Address, data, select and write enable are shared by all slaves.
    assign s_we    = m_we;
    assign s_adr   = m_adr;
    assign s_dat_o = m_dat_i;
    assign s_sel   = m_sel;

    // The counter only runs inside ACTIVE, so every new cycle starts from zero.
    assign tmo_clear = (state != ACTIVE);

    wb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk     (i_clk),
        .rst     (i_rst),
        .clear   (tmo_clear),
        .enable  (tmo_en),
        .expired (tmo_expired)
    );

    // State and selected-slave registers; the index is latched once at decode time.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            sel_q <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && accept) begin
                sel_q <= req_idx;
            end
        end
    end

    // Next-state decode, slave strobing and combinational response forwarding.
    always_comb begin
        next_state = state;
        s_cyc      = '0;
        s_stb      = '0;
        m_ack      = 1'b0;
        m_err      = 1'b0;
        m_rty      = 1'b0;
        m_dat_o    = '0;
        tmo_en     = 1'b0;
        case (state)
            IDLE: begin
                if (m_cyc && m_stb) begin
                    next_state = SLAVE_EN[req_idx] ? ACTIVE : ERR;
                end
            end
            ACTIVE: begin
                s_cyc[sel_q] = m_cyc;
                s_stb[sel_q] = m_stb;
                for (int k = 0; k < NUM_SLAVES; k++) begin
                    if (sel_q == slave_idx_t'(k)) begin
                        m_dat_o = s_dat_i[k*WB_DATA_W +: WB_DATA_W];
                    end
                end
                // An aborted cycle produces no response even if the slave answers late.
                if (m_cyc) begin
                    m_ack = s_ack[sel_q];
                    m_err = s_err[sel_q];
                    m_rty = s_rty[sel_q];
                end
                if (!m_cyc || m_ack || m_err || m_rty) begin
                    next_state = IDLE;
                end else if (tmo_expired) begin
                    next_state = ERR;
                end else begin
                    tmo_en = 1'b1;
                end
            end
            ERR: begin
                m_err      = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_bus_decoder.sv
// Directed testbench for wb_bus_decoder with region 3 disabled and an 8-cycle timeout.
module tb_wb_bus_decoder;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        m_cyc, m_stb, m_we;
    logic [23:0] m_adr;
    logic [15:0] m_dat_i;
    logic [1:0]  m_sel;
    logic [15:0] m_dat_o;
    logic        m_ack, m_err, m_rty;
    logic [3:0]  s_cyc, s_stb;
    logic        s_we;
    logic [23:0] s_adr;
    logic [15:0] s_dat_o;
    logic [1:0]  s_sel;
    logic [63:0] s_dat_i;
    logic [3:0]  s_ack, s_err, s_rty;

    int tests_run    = 0;
    int tests_failed = 0;

    wb_bus_decoder #(
        .SLAVE_EN (4'b0111),
        .TIMEOUT  (8)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .m_cyc   (m_cyc),
        .m_stb   (m_stb),
        .m_we    (m_we),
        .m_adr   (m_adr),
        .m_dat_i (m_dat_i),
        .m_sel   (m_sel),
        .m_dat_o (m_dat_o),
        .m_ack   (m_ack),
        .m_err   (m_err),
        .m_rty   (m_rty),
        .s_cyc   (s_cyc),
        .s_stb   (s_stb),
        .s_we    (s_we),
        .s_adr   (s_adr),
        .s_dat_o (s_dat_o),
        .s_sel   (s_sel),
        .s_dat_i (s_dat_i),
        .s_ack   (s_ack),
        .s_err   (s_err),
        .s_rty   (s_rty)
    );

    // 10 ns clock.
    always #5 i_clk = ~i_clk;

    // Inputs change 1 ns after the rising edge; checks happen 4 ns after it.
    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic mid_cycle();
        #3;
    endtask

    task automatic idle_bus();
        m_cyc   = 1'b0;
        m_stb   = 1'b0;
        m_we    = 1'b0;
        m_adr   = 24'h000000;
        m_dat_i = 16'h0000;
        m_sel   = 2'b00;
        s_dat_i = 64'h4444_3333_2222_1111;
        s_ack   = 4'b0000;
        s_err   = 4'b0000;
        s_rty   = 4'b0000;
    endtask

    task automatic request(input logic [23:0] adr, input logic we, input logic [15:0] dat);
        m_cyc   = 1'b1;
        m_stb   = 1'b1;
        m_we    = we;
        m_adr   = adr;
        m_dat_i = dat;
        m_sel   = 2'b11;
    endtask

    // Reset with the master requesting: everything quiet, shared signals mirror the master.
    task automatic test_reset();
        idle_bus();
        i_rst   = 1'b1;
        m_cyc   = 1'b1;
        m_stb   = 1'b1;
        m_we    = 1'b1;
        m_adr   = 24'h123456;
        m_dat_i = 16'hA5A5;
        m_sel   = 2'b10;
        s_ack   = 4'b1111;
        next_cycle();
        next_cycle();
        mid_cycle();
        tests_run++;
        if ({m_ack, m_err, m_rty} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL reset_resp: got %b expected 000", {m_ack, m_err, m_rty});
        end
        tests_run++;
        if ({s_cyc, s_stb} !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL reset_strobes: got %h expected 00", {s_cyc, s_stb});
        end
        tests_run++;
        if (m_dat_o !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_dat: got %h expected 0000", m_dat_o);
        end
        tests_run++;
        if ({s_adr, s_we, s_dat_o, s_sel} !== {24'h123456, 1'b1, 16'hA5A5, 2'b10}) begin
            tests_failed++;
            $display("[TB] FAIL reset_passthru: got %h %b %h %b expected 123456 1 a5a5 10",
                     s_adr, s_we, s_dat_o, s_sel);
        end
        next_cycle();
        i_rst = 1'b0;
        idle_bus();
        next_cycle();
    endtask

    // Read from slave 2 with ack three cycles after strobe, then a back-to-back write.
    task automatic test_read_slave2();
        request(24'h800010, 1'b0, 16'h0000);
        mid_cycle();
        tests_run++;
        if (s_stb !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL rd_decode_cycle: s_stb got %b expected 0000", s_stb);
        end
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            mid_cycle();
            tests_run++;
            if ({s_cyc, s_stb, m_ack} !== {4'b0100, 4'b0100, 1'b0}) begin
                tests_failed++;
                $display("[TB] FAIL rd_wait_c%0d: cyc/stb/ack got %b %b %b expected 0100 0100 0",
                         c, s_cyc, s_stb, m_ack);
            end
        end
        next_cycle();
        s_dat_i = 64'h4444_BEEF_2222_1111;
        s_ack   = 4'b0100;
        mid_cycle();
        tests_run++;
        if ({m_ack, m_dat_o, s_stb} !== {1'b1, 16'hBEEF, 4'b0100}) begin
            tests_failed++;
            $display("[TB] FAIL rd_ack: ack/dat/stb got %b %h %b expected 1 beef 0100",
                     m_ack, m_dat_o, s_stb);
        end
        next_cycle();
        s_ack = 4'b0000;
        request(24'h800010, 1'b1, 16'h5A5A);
        mid_cycle();
        tests_run++;
        if ({s_cyc, s_stb, m_ack, m_err, m_rty} !== 11'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_idle: cyc/stb/resp got %b %b %b%b%b expected all 0",
                     s_cyc, s_stb, m_ack, m_err, m_rty);
        end
        tests_run++;
        if ({s_we, s_dat_o} !== {1'b1, 16'h5A5A}) begin
            tests_failed++;
            $display("[TB] FAIL b2b_wrdata: we/dat got %b %h expected 1 5a5a", s_we, s_dat_o);
        end
        next_cycle();
        s_ack = 4'b0100;
        mid_cycle();
        tests_run++;
        if ({s_stb, m_ack} !== {4'b0100, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL b2b_ack: stb/ack got %b %b expected 0100 1", s_stb, m_ack);
        end
        next_cycle();
        idle_bus();
        next_cycle();
    endtask

    // Write to the disabled region 3: one error cycle and no slave activity.
    task automatic test_unmapped();
        request(24'hC00000, 1'b1, 16'h1234);
        mid_cycle();
        tests_run++;
        if ({s_cyc, m_err} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL unmap_c0: cyc/err got %b %b expected 0000 0", s_cyc, m_err);
        end
        next_cycle();
        mid_cycle();
        tests_run++;
        if ({s_cyc, s_stb, m_err, m_ack, m_dat_o} !== {8'h00, 1'b1, 1'b0, 16'h0000}) begin
            tests_failed++;
            $display("[TB] FAIL unmap_err: cyc/stb/err/ack/dat got %b %b %b %b %h expected 0000 0000 1 0 0000",
                     s_cyc, s_stb, m_err, m_ack, m_dat_o);
        end
        next_cycle();
        idle_bus();
        mid_cycle();
        tests_run++;
        if ({s_cyc, m_err} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL unmap_c2: cyc/err got %b %b expected 0000 0", s_cyc, m_err);
        end
        next_cycle();
    endtask

    // Silent slave 0: strobe for cycles 1..8, error in cycle 9, quiet afterwards.
    task automatic test_timeout();
        request(24'h000000, 1'b0, 16'h0000);
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            mid_cycle();
            tests_run++;
            if ({s_stb, s_cyc, m_err} !== {4'b0001, 4'b0001, 1'b0}) begin
                tests_failed++;
                $display("[TB] FAIL tmo_wait_c%0d: stb/cyc/err got %b %b %b expected 0001 0001 0",
                         c, s_stb, s_cyc, m_err);
            end
        end
        next_cycle();
        mid_cycle();
        tests_run++;
        if ({m_err, s_stb, s_cyc} !== {1'b1, 8'h00}) begin
            tests_failed++;
            $display("[TB] FAIL tmo_err: err/stb/cyc got %b %b %b expected 1 0000 0000",
                     m_err, s_stb, s_cyc);
        end
        next_cycle();
        idle_bus();
        mid_cycle();
        tests_run++;
        if ({m_err, s_stb} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL tmo_after: err/stb got %b %b expected 0 0000", m_err, s_stb);
        end
        next_cycle();
    endtask

    // Slave 1 retries while slave 3 acks spuriously; only slave 1 is forwarded.
    task automatic test_retry_spurious();
        request(24'h400000, 1'b0, 16'h0000);
        s_ack = 4'b1111;
        mid_cycle();
        tests_run++;
        if ({m_ack, m_err, m_rty} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL idle_ignore: resp got %b expected 000", {m_ack, m_err, m_rty});
        end
        next_cycle();
        s_ack = 4'b1000;
        s_rty = 4'b0010;
        mid_cycle();
        tests_run++;
        if ({m_rty, m_ack, m_err, s_stb} !== {3'b100, 4'b0010}) begin
            tests_failed++;
            $display("[TB] FAIL rty_fwd: rty/ack/err/stb got %b %b %b %b expected 1 0 0 0010",
                     m_rty, m_ack, m_err, s_stb);
        end
        next_cycle();
        idle_bus();
        next_cycle();
    endtask

    // Simultaneous ack and err from slave 2 are both forwarded; no error cycle follows.
    task automatic test_ack_err();
        request(24'h812345, 1'b0, 16'h0000);
        next_cycle();
        s_ack = 4'b0100;
        s_err = 4'b0100;
        mid_cycle();
        tests_run++;
        if ({m_ack, m_err, m_rty} !== 3'b110) begin
            tests_failed++;
            $display("[TB] FAIL ack_err_fwd: ack/err/rty got %b expected 110", {m_ack, m_err, m_rty});
        end
        next_cycle();
        idle_bus();
        mid_cycle();
        tests_run++;
        if ({m_ack, m_err, s_stb} !== 6'b0) begin
            tests_failed++;
            $display("[TB] FAIL ack_err_after: ack/err/stb got %b %b %b expected 0 0 0000",
                     m_ack, m_err, s_stb);
        end
        next_cycle();
    endtask

    // Master abandons a slave-0 cycle at cycle 2, then a slave-1 request decodes normally.
    task automatic test_abort();
        request(24'h000100, 1'b0, 16'h0000);
        next_cycle();
        mid_cycle();
        tests_run++;
        if (s_cyc !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL abort_c1: s_cyc got %b expected 0001", s_cyc);
        end
        next_cycle();
        m_cyc = 1'b0;
        m_stb = 1'b0;
        mid_cycle();
        tests_run++;
        if ({s_cyc, s_stb, m_ack, m_err, m_rty} !== 11'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_c2: cyc/stb/resp got %b %b %b%b%b expected all 0",
                     s_cyc, s_stb, m_ack, m_err, m_rty);
        end
        next_cycle();
        request(24'h400200, 1'b0, 16'h0000);
        mid_cycle();
        tests_run++;
        if ({s_cyc, m_err} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_c3: cyc/err got %b %b expected 0000 0", s_cyc, m_err);
        end
        next_cycle();
        s_ack   = 4'b0010;
        s_dat_i = 64'h4444_3333_CAFE_1111;
        mid_cycle();
        tests_run++;
        if ({s_cyc, m_ack, m_dat_o} !== {4'b0010, 1'b1, 16'hCAFE}) begin
            tests_failed++;
            $display("[TB] FAIL abort_next: cyc/ack/dat got %b %b %h expected 0010 1 cafe",
                     s_cyc, m_ack, m_dat_o);
        end
        next_cycle();
        idle_bus();
        next_cycle();
    endtask

    // Reset during ACTIVE drops everything next cycle; a fresh cycle then times out in full.
    task automatic test_reset_mid();
        request(24'h800000, 1'b0, 16'h0000);
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
        end
        mid_cycle();
        tests_run++;
        if (s_stb !== 4'b0100) begin
            tests_failed++;
            $display("[TB] FAIL rstmid_active: s_stb got %b expected 0100", s_stb);
        end
        next_cycle();
        i_rst = 1'b1;
        next_cycle();
        mid_cycle();
        tests_run++;
        if ({s_cyc, s_stb, m_ack, m_err, m_rty, m_dat_o} !== 27'b0) begin
            tests_failed++;
            $display("[TB] FAIL rstmid_quiet: cyc/stb/resp/dat got %b %b %b%b%b %h expected all 0",
                     s_cyc, s_stb, m_ack, m_err, m_rty, m_dat_o);
        end
        i_rst = 1'b0;
        idle_bus();
        next_cycle();
        request(24'h000000, 1'b0, 16'h0000);
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            mid_cycle();
            tests_run++;
            if ({s_stb, m_err} !== {4'b0001, 1'b0}) begin
                tests_failed++;
                $display("[TB] FAIL rstmid_tmo_c%0d: stb/err got %b %b expected 0001 0", c, s_stb, m_err);
            end
        end
        next_cycle();
        mid_cycle();
        tests_run++;
        if ({m_err, s_stb} !== {1'b1, 4'b0000}) begin
            tests_failed++;
            $display("[TB] FAIL rstmid_tmo_err: err/stb got %b %b expected 1 0000", m_err, s_stb);
        end
        next_cycle();
        idle_bus();
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_read_slave2();
        test_unmapped();
        test_timeout();
        test_retry_spurious();
        test_ack_err();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Guard against a stuck simulation.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/wb_bus_decoder.md
# wb_bus_decoder

Single-master Wishbone classic decoder placed directly downstream of the core's external bus port; it consumes the core's cycle and fans it out to four slave ports. The slave is selected by address bits [23:22]. Each cycle is tracked by a small FSM that forwards the slave's ack, err or rty to the master. The block also terminates cycles to disabled slaves and cycles that exceed a timeout with an error, so that a missing or hung peripheral cannot stall the core forever.

## Interface
Parameters:
- SLAVE_EN, 4'b1111, per-slave enable mask; bit k=0 makes region k unmapped.
- TIMEOUT, 64, cycles in ACTIVE before forced error; legal range 2..255.

Ports. Widths are WB_DATA_W=16, WB_ADDR_W=24, WB_SEL_BITS=2.

Clock, reset, master side:
- i_clk  in  1  clock; one clock domain.
- i_rst  in  1  synchronous active-high reset.
- m_cyc  in  1  master cycle.
- m_stb  in  1  master strobe.
- m_we  in  1  write enable.
- m_adr  in  24  byte/word address.
- m_dat_i  in  16  write data.
- m_sel  in  2  byte select.
- m_dat_o  out  16  read data.
- m_ack  out  1  cycle acknowledge.
- m_err  out  1  cycle error.
- m_rty  out  1  cycle retry.

Slave side:
- s_cyc  out  4  one-hot slave cycle.
- s_stb  out  4  one-hot slave strobe.
- s_we  out  1  shared write enable.
- s_adr  out  24  shared address.
- s_dat_o  out  16  shared write data.
- s_sel  out  2  shared byte select.
- s_dat_i  in  64  read data, slave k at [16k+15:16k].
- s_ack  in  4  per-slave acknowledge.
- s_err  in  4  per-slave error.
- s_rty  in  4  per-slave retry.

## Operation
- FSM states: IDLE, ACTIVE, ERR.
- Registered: state, 2-bit selected index `sel_q`, timeout counter `tmo` (8 bit).
- IDLE:
  - m_cyc&m_stb with SLAVE_EN[m_adr[23:22]]=1: latch index, clear tmo, go to ACTIVE.
  - Same request to a disabled region: go to ERR.
- ACTIVE:
  - s_cyc[sel_q]=m_cyc and s_stb[sel_q]=m_stb; all other bits 0.
  - s_we, s_adr, s_dat_o and s_sel pass through combinationally from the master.
  - Master response is a combinational forward: m_ack=s_ack[sel_q], m_err=s_err[sel_q], m_rty=s_rty[sel_q], m_dat_o=s_dat_i slice sel_q.
  - Any of those three responses asserted: next state IDLE.
  - No response: tmo increments by 1.
  - tmo==TIMEOUT-1 with no response: drop s_stb/s_cyc next cycle and go to ERR.
- ERR:
  - m_err=1 for exactly one cycle, then IDLE.
  - m_dat_o=16'h0000; all s_cyc and s_stb are 0.
- Abort: m_cyc low while in ACTIVE → IDLE next cycle. No response is generated and slave cyc/stb fall the same cycle.
- Slave responses arriving while a slave is not selected are ignored. Response bits from non-selected slaves are never forwarded.
- Simultaneous ack and err from the selected slave: both are forwarded and the state goes to IDLE. The master's priority rules apply.
- Only one cycle is outstanding; there is no pipelining.
- The address is not re-decoded mid-cycle. A master must hold m_adr stable until it receives a response.

## Timing
- Reset (i_rst=1 at edge): state=IDLE, sel_q=0, tmo=0.
  - Consequently all outputs are 0 (s_adr, s_we, s_dat_o and s_sel still mirror master inputs), including when reset hits mid-transaction.
- Request at cycle 0 (IDLE):
  - Slave strobe asserted in cycle 1.
  - A slave acking combinationally gives m_ack in cycle 1, so minimum latency is 1 cycle.
- Unmapped request at cycle 0: m_err in cycle 1 only.
- Timeout: a slave that never responds gives s_stb high for cycles 1..TIMEOUT, then m_err at cycle TIMEOUT+1.
- After any response the block is in IDLE the following cycle. A new request is accepted there, giving back-to-back transfers with 1 idle decode cycle.

## Structure
- WB_DATA_W, WB_ADDR_W and WB_SEL_BITS move into the shared config header, used by this block and the core bus modules.
- The state encoding constants (IDLE, ACTIVE, ERR) are local to this block.
- Sub-module `wb_timeout_counter`: clear and enable inputs, `expired` output at TIMEOUT-1. It is reused later for the arbiter watchdog.

## Test plan
- Read from slave 2 at m_adr=24'h800010, slave returns 16'hBEEF with ack 3 cycles after s_stb → s_stb=4'b0100; m_ack and m_dat_o=16'hBEEF appear exactly in that cycle; state is IDLE next cycle.
- SLAVE_EN=4'b0111, write to m_adr=24'hC00000 → no s_cyc bit ever set; m_err=1 in cycle 1 only.
- TIMEOUT=8, slave 0 silent → s_stb[0] high for cycles 1..8; m_err in cycle 9; slave strobe low from cycle 9.
- Slave 1 asserts rty, and slave 3 asserts a spurious ack while slave 1 is selected → m_rty=1, m_ack=0.
- Master drops m_cyc at cycle 2 of a slave-0 cycle → s_cyc=0 the same cycle; no m_ack/m_err; next request decodes normally.
- i_rst pulsed during ACTIVE → all response outputs and s_stb/s_cyc are 0 the next cycle; state IDLE, tmo=0.
